// File: rtl/i2c_slave_pkg.sv
// Shared types and widths for the I2C slave controller and its shift register.
package i2c_slave_pkg;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 4;

  localparam logic [CNT_W-1:0] BIT_CNT_MAX = CNT_W'(DATA_W);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    RX_BYTE,
    RX_ACK,
    TX_BYTE,
    TX_ACK,
    WAIT_STOP
  } state_e;

endpackage

// File: rtl/i2c_slave_shift_reg.sv
// MSB-first byte shift register with a bit counter that saturates at DATA_W.
module i2c_slave_shift_reg
  import i2c_slave_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              shift,
  input  logic              bit_in,
  output logic [DATA_W-1:0] data,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // Clear beats load beats shift; a load also restarts the bit count.
  always_comb begin
    data_d  = data_q;
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      data_d  = load_data;
      count_d = '0;
    end else if (shift) begin
      data_d = {data_q[DATA_W-2:0], bit_in};
      if (count_q != BIT_CNT_MAX) begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      count_q <= '0;
    end else begin
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign data  = data_q;
  assign count = count_q;

endmodule

// File: rtl/i2c_slave_controller.sv
// I2C slave: address match, byte receive with ACK/NACK, byte transmit with
// underrun fill, START/STOP detection from pre-synchronized SCL/SDA.
module i2c_slave_controller
  import i2c_slave_pkg::*;
#(
  parameter logic [ADDR_W-1:0] OWN_ADDR = 7'h2A
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl_sync,
  input  logic              sda_sync,
  input  logic              rising_edge,
  input  logic              falling_edge,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  input  logic              rx_full,
  output logic              sda_out,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_taken,
  output logic              busy,
  output logic              rw_mode,
  output logic              tx_underrun
);

  state_e            state_q, state_d;
  logic              sda_prev_q, sda_prev_d;
  logic              sda_out_q, sda_out_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              tx_taken_q, tx_taken_d;
  logic              tx_underrun_q, tx_underrun_d;
  logic              busy_q, busy_d;
  logic              rw_mode_q, rw_mode_d;

  logic              sr_clear, sr_load, sr_shift;
  logic [DATA_W-1:0] sr_load_data, sr_data;
  logic [CNT_W-1:0]  sr_count;

  logic              start_c, stop_c, last_bit_c;
  logic [DATA_W-1:0] byte_c, tx_byte_c;

  assign start_c    = scl_sync & sda_prev_q & ~sda_sync;
  assign stop_c     = scl_sync & ~sda_prev_q & sda_sync;
  assign last_bit_c = rising_edge & (sr_count == CNT_W'(DATA_W - 1));
  assign byte_c     = {sr_data[DATA_W-2:0], sda_sync};
  assign tx_byte_c  = tx_valid ? tx_data : '1;

  i2c_slave_shift_reg u_shift_reg (
    .clk       (clk),
    .rst       (rst),
    .clear     (sr_clear),
    .load      (sr_load),
    .load_data (sr_load_data),
    .shift     (sr_shift),
    .bit_in    (sda_sync),
    .data      (sr_data),
    .count     (sr_count)
  );

  always_comb begin
    state_d       = state_q;
    sda_prev_d    = sda_sync;
    sda_out_d     = sda_out_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    tx_taken_d    = 1'b0;
    tx_underrun_d = 1'b0;
    busy_d        = busy_q;
    rw_mode_d     = rw_mode_q;
    sr_clear      = 1'b0;
    sr_load       = 1'b0;
    sr_shift      = 1'b0;
    sr_load_data  = tx_byte_c;

    if (start_c) begin
      state_d   = ADDR;
      sda_out_d = 1'b1;
      sr_clear  = 1'b1;
    end else if (stop_c) begin
      state_d   = IDLE;
      sda_out_d = 1'b1;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE, WAIT_STOP: ;
        ADDR: begin
          sr_shift = rising_edge;
          if (last_bit_c) begin
            if (byte_c[DATA_W-1:1] == OWN_ADDR) begin
              state_d   = ADDR_ACK;
              rw_mode_d = byte_c[0];
              busy_d    = 1'b1;
            end else begin
              state_d = WAIT_STOP;
            end
          end
        end
        // ACK slots use sda_out_q as the phase: released means ACK not yet driven.
        ADDR_ACK: begin
          if (falling_edge) begin
            if (sda_out_q) begin
              sda_out_d = 1'b0;
            end else if (rw_mode_q) begin
              state_d       = TX_BYTE;
              sr_load       = 1'b1;
              sda_out_d     = tx_byte_c[DATA_W-1];
              tx_taken_d    = tx_valid;
              tx_underrun_d = ~tx_valid;
            end else begin
              state_d   = RX_BYTE;
              sda_out_d = 1'b1;
              sr_clear  = 1'b1;
            end
          end
        end
        RX_BYTE: begin
          sr_shift = rising_edge;
          if (last_bit_c) begin
            state_d    = RX_ACK;
            rx_data_d  = byte_c;
            rx_valid_d = 1'b1;
          end
        end
        RX_ACK: begin
          if (falling_edge) begin
            if (!sda_out_q) begin
              state_d   = RX_BYTE;
              sda_out_d = 1'b1;
              sr_clear  = 1'b1;
            end else if (rx_full) begin
              state_d = WAIT_STOP;
            end else begin
              sda_out_d = 1'b0;
            end
          end
        end
        // Shifting on every rise leaves the next bit to send in the MSB.
        TX_BYTE: begin
          sr_shift = rising_edge;
          if (falling_edge) begin
            if (sr_count == BIT_CNT_MAX) begin
              state_d   = TX_ACK;
              sda_out_d = 1'b1;
            end else begin
              sda_out_d = sr_data[DATA_W-1];
            end
          end
        end
        TX_ACK: begin
          if (rising_edge && sda_sync) begin
            state_d = WAIT_STOP;
          end else if (falling_edge) begin
            state_d       = TX_BYTE;
            sr_load       = 1'b1;
            sda_out_d     = tx_byte_c[DATA_W-1];
            tx_taken_d    = tx_valid;
            tx_underrun_d = ~tx_valid;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      sda_prev_q    <= 1'b1;
      sda_out_q     <= 1'b1;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      tx_taken_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
      busy_q        <= 1'b0;
      rw_mode_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      sda_prev_q    <= sda_prev_d;
      sda_out_q     <= sda_out_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      tx_taken_q    <= tx_taken_d;
      tx_underrun_q <= tx_underrun_d;
      busy_q        <= busy_d;
      rw_mode_q     <= rw_mode_d;
    end
  end

  assign sda_out     = sda_out_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_taken    = tx_taken_q;
  assign tx_underrun = tx_underrun_q;
  assign busy        = busy_q;
  assign rw_mode     = rw_mode_q;

endmodule

// File: tb/tb_i2c_slave_controller.sv
// Bit-banged I2C master with a transaction-level model feeding a scoreboard;
// a monitor compares slave-driven SDA slots and output pulses as they occur.
module tb_i2c_slave_controller;

  localparam logic [6:0] OWN = 7'h2A;

  logic       clk = 1'b0;
  logic       rst, scl_sync, m_sda, rising_edge, falling_edge;
  logic       tx_valid, rx_full, sda_sync;
  logic [7:0] tx_data;
  logic       sda_out, rx_valid, tx_taken, busy, rw_mode, tx_underrun;
  logic [7:0] rx_data;

  always #5 clk = ~clk;

  // Open-drain bus: the line is low if either side pulls it low.
  assign sda_sync = m_sda & sda_out;

  i2c_slave_controller #(.OWN_ADDR(OWN)) dut (
    .clk          (clk),
    .rst          (rst),
    .scl_sync     (scl_sync),
    .sda_sync     (sda_sync),
    .rising_edge  (rising_edge),
    .falling_edge (falling_edge),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .rx_full      (rx_full),
    .sda_out      (sda_out),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .tx_taken     (tx_taken),
    .busy         (busy),
    .rw_mode      (rw_mode),
    .tx_underrun  (tx_underrun)
  );

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_rx[$];
  int         exp_tx[$];
  logic       exp_sda[$];
  logic       mon_sample = 1'b0;
  logic [7:0] wq[$];
  logic       vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: pops expectations only when the DUT presents something.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) begin
        if (exp_rx.size() == 0) check("rx_valid_unexpected", 32'(rx_valid), 32'd0);
        else check("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
      end
      if (tx_taken || tx_underrun) begin
        if (exp_tx.size() == 0) check("tx_evt_unexpected", 32'({tx_underrun, tx_taken}), 32'd0);
        else check("tx_evt", 32'({tx_underrun, tx_taken}), 32'(exp_tx.pop_front()));
      end
      if (rising_edge) begin
        if (!mon_sample) check("sda_released", 32'(sda_out), 32'd1);
        else if (exp_sda.size() == 0) check("sda_slot_unexpected", 32'(sda_out), 32'd2);
        else check("sda_slot", 32'(sda_out), 32'(exp_sda.pop_front()));
      end
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scl_to(input logic v);
    rising_edge  = v & ~scl_sync;
    falling_edge = ~v & scl_sync;
    scl_sync     = v;
    wait_clks(1);
    rising_edge  = 1'b0;
    falling_edge = 1'b0;
    wait_clks(2);
  endtask

  task automatic bus_start();
    m_sda = 1'b1;
    if (!scl_sync) begin
      wait_clks(1);
      scl_to(1'b1);
    end
    wait_clks(1);
    m_sda = 1'b0;
    wait_clks(2);
    scl_to(1'b0);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0;
    wait_clks(1);
    scl_to(1'b1);
    m_sda = 1'b1;
    wait_clks(3);
  endtask

  task automatic put_bit(input logic b);
    m_sda = b;
    wait_clks(1);
    scl_to(1'b1);
    scl_to(1'b0);
  endtask

  task automatic put_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) put_bit(b[i]);
  endtask

  // Master releases SDA and expects the slave to present exp on this clock.
  task automatic slave_bit(input logic exp);
    m_sda = 1'b1;
    wait_clks(1);
    exp_sda.push_back(exp);
    mon_sample = 1'b1;
    scl_to(1'b1);
    mon_sample = 1'b0;
    scl_to(1'b0);
  endtask

  // Write transaction model: a matched slave ACKs the address, reports every
  // byte until it NACKs one for rx_full, then ignores the rest of the frame.
  task automatic write_txn(input logic [6:0] addr, input logic full, input logic stop);
    logic live;
    live    = (addr == OWN);
    rx_full = full;
    bus_start();
    put_byte({addr, 1'b0});
    slave_bit(!live);
    check("busy_after_addr", 32'(busy), 32'(live));
    if (live) check("rw_mode_w", 32'(rw_mode), 32'd0);
    foreach (wq[i]) begin
      if (live) exp_rx.push_back(wq[i]);
      put_byte(wq[i]);
      slave_bit(!(live && !full));
      if (full) live = 1'b0;
    end
    rx_full = 1'b0;
    if (stop) begin
      bus_stop();
      check("busy_after_stop", 32'(busy), 32'd0);
    end
  endtask

  // Read transaction model: each byte is the offered tx_data, or 0xFF when
  // none was offered; the master ACKs all bytes but the last.
  task automatic read_txn(input logic [6:0] addr, input logic stop);
    logic       live;
    logic [7:0] e;
    live     = (addr == OWN);
    tx_data  = wq[0];
    tx_valid = vq[0];
    if (live) exp_tx.push_back(vq[0] ? 1 : 2);
    bus_start();
    put_byte({addr, 1'b1});
    slave_bit(!live);
    check("busy_after_addr", 32'(busy), 32'(live));
    if (live) check("rw_mode_r", 32'(rw_mode), 32'd1);
    for (int i = 0; i < wq.size(); i++) begin
      e = vq[i] ? wq[i] : 8'hFF;
      for (int b = 7; b >= 0; b--) slave_bit(live ? e[b] : 1'b1);
      if (i < wq.size() - 1) begin
        tx_data  = wq[i+1];
        tx_valid = vq[i+1];
        if (live) exp_tx.push_back(vq[i+1] ? 1 : 2);
      end
      put_bit(i == wq.size() - 1);
    end
    if (stop) begin
      bus_stop();
      check("busy_after_stop", 32'(busy), 32'd0);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_sda_out", 32'(sda_out), 32'd1);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_tx_taken", 32'(tx_taken), 32'd0);
    check("rst_tx_underrun", 32'(tx_underrun), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rw_mode", 32'(rw_mode), 32'd0);
  endtask

  initial begin
    rst = 1'b1; scl_sync = 1'b1; m_sda = 1'b1; rising_edge = 1'b0; falling_edge = 1'b0;
    tx_valid = 1'b0; tx_data = 8'h00; rx_full = 1'b0;
    wait_clks(3);
    check_reset_outputs();
    rst = 1'b0;
    wait_clks(2);

    // Plain write of 0xA5 to the own address.
    wq.delete(); wq.push_back(8'hA5);
    write_txn(OWN, 1'b0, 1'b1);
    check("write_rx_data_hold", 32'(rx_data), 32'hA5);

    // Read of 0x3C, NACKed; slave must then ignore a further byte.
    wq.delete(); vq.delete(); wq.push_back(8'h3C); vq.push_back(1'b1);
    read_txn(OWN, 1'b0);
    put_byte(8'h00);
    check("busy_wait_stop", 32'(busy), 32'd1);
    bus_stop();
    check("busy_after_stop", 32'(busy), 32'd0);

    // Foreign address: no drive, no pulses.
    wq.delete(); wq.push_back(8'h5A); wq.push_back(8'h11);
    write_txn(7'h22, 1'b0, 1'b1);

    // Receive sink full: data byte NACKed, remainder ignored.
    wq.delete(); wq.push_back(8'h77); wq.push_back(8'h88);
    write_txn(OWN, 1'b1, 1'b1);

    // Repeated START from write into a read with nothing to send.
    wq.delete(); wq.push_back(8'h5C);
    write_txn(OWN, 1'b0, 1'b0);
    wq.delete(); vq.delete(); wq.push_back(8'h99); vq.push_back(1'b0);
    read_txn(OWN, 1'b1);

    // Reset in the middle of a received byte.
    bus_start();
    put_byte({OWN, 1'b0});
    slave_bit(1'b0);
    for (int i = 0; i < 4; i++) put_bit(1'b1);
    rst = 1'b1;
    wait_clks(1);
    check_reset_outputs();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) put_bit(1'b0);
    bus_stop();
    check("busy_post_rst", 32'(busy), 32'd0);

    // Randomized traffic against the transaction model.
    for (int t = 0; t < 24; t++) begin
      logic [6:0] a;
      int         n;
      a = ($urandom_range(0, 3) == 0) ? 7'($urandom) : OWN;
      n = $urandom_range(1, 3);
      wq.delete(); vq.delete();
      for (int k = 0; k < n; k++) begin
        wq.push_back(8'($urandom));
        vq.push_back(1'($urandom_range(0, 3) != 0));
      end
      if ($urandom_range(0, 1) == 1) read_txn(a, 1'b1);
      else write_txn(a, 1'($urandom_range(0, 3) == 0), 1'b1);
    end

    wait_clks(4);
    check("exp_rx_drained", 32'(exp_rx.size()), 32'd0);
    check("exp_tx_drained", 32'(exp_tx.size()), 32'd0);
    check("exp_sda_drained", 32'(exp_sda.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_slave_controller.md
I2C_SLAVE_CONTROLLER -- requirements
Module: i2c_slave_controller

Interface
REQ-001 SHALL have a parameter OWN_ADDR, default 7'h2A, giving the 7-bit slave address matched after START.
REQ-002 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port scl_sync, input, 1, synchronized SCL level.
REQ-005 SHALL have port sda_sync, input, 1, synchronized SDA level.
REQ-006 SHALL have port rising_edge, input, 1, one-cycle pulse per SCL rise from the edge detector.
REQ-007 SHALL have port falling_edge, input, 1, one-cycle pulse per SCL fall from the edge detector.
REQ-008 SHALL have port tx_data, input, 8, byte for the next master read.
REQ-009 SHALL have port tx_valid, input, 1, tx_data holds a fresh byte.
REQ-010 SHALL have port rx_full, input, 1, receive sink cannot accept a byte; forces NACK.
REQ-011 SHALL have port sda_out, output, 1, 0 = drive SDA low, 1 = release.
REQ-012 SHALL have port rx_data, output, 8, last received data byte.
REQ-013 SHALL have port rx_valid, output, 1, one-cycle pulse when rx_data is updated.
REQ-014 SHALL have port tx_taken, output, 1, one-cycle pulse when tx_data is loaded.
REQ-015 SHALL have port busy, output, 1, high between address match and STOP.
REQ-016 SHALL have port rw_mode, output, 1, R/W bit of the matched address byte.
REQ-017 SHALL have port tx_underrun, output, 1, one-cycle pulse when 0xFF is sent because tx_valid was low.

Function
REQ-018 SHALL register sda_sync one cycle (sda_prev); START = scl_sync high and sda_prev 1 -> sda_sync 0; STOP = scl_sync high and sda_prev 0 -> sda_sync 1.
REQ-019 SHALL use states IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP.
REQ-020 SHALL go to ADDR and clear the bit counter on START from any state (repeated START included); STOP in any state -> IDLE, sda_out 1, busy 0.
REQ-021 SHALL sample SDA MSB-first on rising_edge; change sda_out only on falling_edge.
REQ-022 SHALL, in ADDR on the 8th rising_edge, match bits[7:1] to OWN_ADDR; match -> ADDR_ACK, rw_mode = bit0, busy 1; mismatch -> WAIT_STOP, sda_out stays 1.
REQ-023 SHALL, in ADDR_ACK, drive sda_out 0 on the next falling_edge and release on the following falling_edge, then enter RX_BYTE (rw 0) or TX_BYTE (rw 1).
REQ-024 SHALL, for rw 1, load tx_data at the falling_edge ending ADDR_ACK, pulse tx_taken if tx_valid else send 0xFF and pulse tx_underrun, and drive bit7 on that same falling_edge.
REQ-025 SHALL, in RX_BYTE on the 8th rising_edge, update rx_data and pulse rx_valid in the following cycle, then enter RX_ACK.
REQ-026 SHALL, in RX_ACK, ACK (sda_out 0) on the next falling_edge if rx_full is 0, else NACK and go to WAIT_STOP; on ACK release at the next falling_edge, return to RX_BYTE.
REQ-027 SHALL, in TX_BYTE, release SDA on the falling_edge after bit0, enter TX_ACK, and sample master ACK on the 9th rising_edge.
REQ-028 SHALL, on master ACK (0), load the next byte per REQ-024 at the next falling_edge; on NACK (1) go to WAIT_STOP with SDA released.
REQ-029 SHALL clip the bit counter at 0-8 with no wrap, and give START/STOP priority over a coincident rising_edge/falling_edge.

Reset
REQ-030 SHALL on rst: state IDLE, sda_out 1, rx_data 0x00, rx_valid 0, tx_taken 0, tx_underrun 0, busy 0, rw_mode 0, bit counter 0, sda_prev 1.
REQ-031 SHALL let rst mid-transfer abort immediately, release SDA, and ignore bus activity until the next START.

Structure
REQ-032 SHALL place the state enum typedef and constants ADDR_W=7, DATA_W=8 in shared package i2c_slave_pkg.
REQ-033 SHALL implement the 8-bit shift register and bit counter as sub-module i2c_slave_shift_reg.

Verification
REQ-034 SHALL cover write: START, 0x54 (addr 0x2A W), 0xA5, STOP -> two ACK lows, rx_data 0xA5, one rx_valid pulse, busy 1 -> 0.
REQ-035 SHALL cover read: START, 0x55, tx_data 0x3C valid, master NACK -> SDA bits 0,0,1,1,1,1,0,0, tx_taken once, WAIT_STOP.
REQ-036 SHALL cover address 0x22 -> sda_out held 1 for whole frame, busy 0, no pulses.
REQ-037 SHALL cover write with rx_full 1 -> NACK on 9th clock, state WAIT_STOP.
REQ-038 SHALL cover repeated START after write byte, then read with tx_valid 0 -> 0xFF sent, tx_underrun pulse.
REQ-039 SHALL cover rst during RX_BYTE bit 4 -> all outputs at reset values next cycle, SDA released.
